// File: rtl/d_sram_like_bridge_pkg.sv
// Shared CPU definitions for the data-side sram-like bridge:
// FSM encoding, bus size codes and KSEG segment tags.
package d_sram_like_bridge_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [2:0] KSEG0 = 3'b100;
    localparam logic [2:0] KSEG1 = 3'b101;

    // Illegal enable patterns fall back to a word access.
    function automatic logic [1:0] wenToSize(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b0011, 4'b1100:                   size = SIZE_H;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
            default:                            size = SIZE_W;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/d_sram_like_bridge_if.sv
// Split-transaction sram-like data bus between bridge and crossbar.
// The bridge is the master; the crossbar is the slave.
interface d_sram_like_bridge_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size,
        output data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size,
        input  data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/d_sram_like_bridge_addr_map.sv
// Combinational KSEG0/KSEG1 to physical translation.
// Shared with the instruction-side bridge.
module d_sram_like_bridge_addr_map
    import d_sram_like_bridge_pkg::*;
#(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    logic isKseg;

    assign isKseg = (vaddr[31:29] == KSEG0) ||
                    (vaddr[31:29] == KSEG1);

    assign paddr = (MAP_KSEG && isKseg) ?
                   {3'b000, vaddr[28:0]} : vaddr;

endmodule

// File: rtl/d_sram_like_bridge.sv
// Core data SRAM port to sram-like bus bridge: stalls the core
// until data_ok and holds read data while the pipeline is frozen.
module d_sram_like_bridge
    import d_sram_like_bridge_pkg::*;
#(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic        longest_stall,
    output logic [31:0] data_sram_rdata,
    output logic        d_stall,
    d_sram_like_bridge_if.master bus
);

    logic [1:0]  state;
    logic [1:0]  stateNext;
    logic [31:0] rdataHold;
    logic [31:0] physAddr;

    d_sram_like_bridge_addr_map #(
        .MAP_KSEG (MAP_KSEG)
    ) u_addr_map (
        .vaddr (data_sram_addr),
        .paddr (physAddr)
    );

    always_comb begin
        stateNext = state;
        unique case (1'b1)
            (state == S_IDLE): begin
                if (data_sram_en && bus.data_addr_ok)
                    stateNext = S_WAIT;
            end
            (state == S_WAIT): begin
                // A flushed request still drains its data_ok here.
                if (bus.data_data_ok)
                    stateNext = data_sram_en ? S_DONE : S_IDLE;
            end
            (state == S_DONE): begin
                if (!longest_stall || !data_sram_en)
                    stateNext = S_IDLE;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rdataHold <= 32'h0;
        end else begin
            state <= stateNext;
            if (state == S_WAIT && bus.data_data_ok)
                rdataHold <= bus.data_rdata;
        end
    end

    // Gating with rst keeps req/stall low while reset is held.
    assign bus.data_req   = rst && data_sram_en &&
                            (state == S_IDLE);
    assign d_stall        = rst && data_sram_en &&
                            (state != S_DONE);
    assign bus.data_wr    = |data_sram_wen;
    assign bus.data_size  = wenToSize(data_sram_wen);
    assign bus.data_addr  = physAddr;
    assign bus.data_wdata = data_sram_wdata;

    assign data_sram_rdata = rdataHold;

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Directed and randomized bench for d_sram_like_bridge against a
// transaction-level model of the bridge's timing and mapping.
module tb_d_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] sAddr;
    logic [31:0] sWdata;
    logic        lstall;
    logic [31:0] rdata;
    logic        dStall;

    int tests = 0;
    int fails = 0;

    d_sram_like_bridge_if bus ();

    d_sram_like_bridge #(
        .MAP_KSEG (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (sAddr),
        .data_sram_wdata (sWdata),
        .longest_stall   (lstall),
        .data_sram_rdata (rdata),
        .d_stall         (dStall),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] refPhys(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF)
            return va & 32'h1FFF_FFFF;
        return va;
    endfunction

    function automatic logic [31:0] refSize(input logic [3:0] w);
        if (w == 4'd0) return 32'd2;
        if ($countones(w) == 1) return 32'd0;
        if (w == 4'b0011 || w == 4'b1100) return 32'd1;
        return 32'd2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: aDly cycles before addr_ok, data_ok dDly
    // cycles after it, then extra cycles of external stall in DONE.
    task automatic doTxn(input logic [31:0] va, input logic [3:0] w,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int aDly, input int dDly,
                         input int extra, input bit idleAfter);
        en = 1'b1; sAddr = va; wen = w; sWdata = wd; lstall = 1'b1;
        for (int i = 0; i <= aDly; i++) begin
            bus.data_addr_ok = (i == aDly);
            @(negedge clk);
            chk("req_addr_phase", bus.data_req, 1);
            chk("addr", bus.data_addr, refPhys(va));
            chk("stall_addr_phase", dStall, 1);
            if (i == aDly) begin
                chk("size", bus.data_size, refSize(w));
                chk("wr", bus.data_wr, (w != 4'd0));
                chk("wdata", bus.data_wdata, wd);
            end
            step();
        end
        bus.data_addr_ok = 1'b0;
        for (int j = 1; j <= dDly; j++) begin
            bus.data_data_ok = (j == dDly);
            bus.data_rdata = (j == dDly) ? rd : $urandom;
            @(negedge clk);
            chk("req_wait", bus.data_req, 0);
            chk("stall_wait", dStall, 1);
            step();
        end
        bus.data_data_ok = 1'b0;
        bus.data_rdata = $urandom;
        for (int k = 0; k <= extra; k++) begin
            lstall = (k < extra);
            @(negedge clk);
            chk("stall_done", dStall, 0);
            chk("req_done", bus.data_req, 0);
            if (w == 4'd0) chk("rdata_done", rdata, rd);
            step();
        end
        if (idleAfter) begin
            en = 1'b0;
            @(negedge clk);
            chk("stall_idle", dStall, 0);
            chk("req_idle", bus.data_req, 0);
            if (w == 4'd0) chk("rdata_kept", rdata, rd);
            step();
        end
    endtask

    initial begin
        logic [3:0] wenTab [8];
        wenTab = '{4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

        rst = 1'b0; en = 1'b1; wen = 4'h0; sAddr = 32'h8000_0000;
        sWdata = 32'h0; lstall = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        bus.data_rdata = 32'h0;
        @(negedge clk);
        chk("rst_req", bus.data_req, 0);
        chk("rst_stall", dStall, 0);
        chk("rst_rdata", rdata, 0);
        en = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Basic read, data_ok two cycles after addr_ok.
        doTxn(32'h8000_0010, 4'h0, 32'h0, 32'h1234_5678,
              0, 2, 0, 1'b1);
        // Byte write through KSEG1.
        doTxn(32'hA000_0002, 4'b0100, 32'h00AB_0000, 32'h0,
              0, 1, 0, 1'b1);
        // Pipeline frozen three extra cycles after completion.
        doTxn(32'h8000_0100, 4'h0, 32'h0, 32'hCAFE_F00D,
              0, 1, 3, 1'b1);
        // addr_ok withheld for four cycles.
        doTxn(32'h1FC0_0040, 4'h0, 32'h0, 32'h0BAD_BEEF,
              4, 1, 0, 1'b0);
        // Back-to-back: next request the cycle after DONE.
        doTxn(32'hC000_0004, 4'hF, 32'h5555_AAAA, 32'h0,
              0, 1, 0, 1'b1);

        // Request dropped before addr_ok.
        en = 1'b1; wen = 4'h0; sAddr = 32'h8000_0200;
        @(negedge clk);
        chk("drop_req_before", bus.data_req, 1);
        step();
        en = 1'b0;
        @(negedge clk);
        chk("drop_req_after", bus.data_req, 0);
        chk("drop_stall", dStall, 0);
        step();

        // Reset while a read is outstanding.
        en = 1'b1; wen = 4'h0; sAddr = 32'h8000_0300; lstall = 1'b1;
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        chk("rstwait_req", bus.data_req, 1);
        step();
        bus.data_addr_ok = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("rstwait_req0", bus.data_req, 0);
        chk("rstwait_stall0", dStall, 0);
        chk("rstwait_rdata0", rdata, 0);
        step();
        rst = 1'b1;
        doTxn(32'h8000_0304, 4'h0, 32'h0, 32'h7777_1234,
              0, 1, 0, 1'b1);

        // Core flushes during WAIT: result dropped, back to IDLE.
        en = 1'b1; wen = 4'h0; sAddr = 32'h8000_0400; lstall = 1'b1;
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        chk("flush_req", bus.data_req, 1);
        step();
        bus.data_addr_ok = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk("flush_stall", dStall, 0);
        chk("flush_req_wait", bus.data_req, 0);
        step();
        bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'hDEAD_0001;
        step();
        bus.data_data_ok = 1'b0;
        doTxn(32'h8000_0404, 4'h0, 32'h0, 32'h4242_4242,
              0, 1, 0, 1'b1);

        // Randomized transactions.
        for (int n = 0; n < 24; n++) begin
            doTxn($urandom, wenTab[$urandom_range(0, 7)], $urandom,
                  $urandom, $urandom_range(0, 3),
                  $urandom_range(1, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/d_sram_like_bridge.md
Name: d_sram_like_bridge

Overview:
Data-side bridge directly downstream of the CPU core's memory stage.
- Takes the core's single-cycle data SRAM request (enable, byte write-enables, address, write data).
- Converts it into the SoC's split-transaction sram-like handshake: req/addr_ok, then data_ok.
- Stalls the core until the transaction completes, and holds read data while the rest of the pipeline is still frozen.
- Sits between the core's data port and the AXI/sram-like crossbar.

Parameters:
- MAP_KSEG, 1: when 1, addresses 0x8000_0000–0xBFFF_FFFF are mapped to physical by clearing addr[31:29]; when 0, addresses pass through unchanged.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- data_sram_en, input, 1: core memory-stage request valid.
- data_sram_wen, input, 4: byte write enables; 0 means read.
- data_sram_addr, input, 32: virtual byte address.
- data_sram_wdata, input, 32: write data, already byte-lane aligned.
- longest_stall, input, 1: core pipeline frozen by any source.
- data_sram_rdata, output, 32: read data returned to the core.
- d_stall, output, 1: stall request to the core.
- data_req, output, 1: bus request.
- data_wr, output, 1: 1 = write.
- data_size, output, 2: 0 = byte, 1 = half, 2 = word.
- data_addr, output, 32: physical address.
- data_wdata, output, 32: write data.
- data_addr_ok, input, 1: bus accepted the address.
- data_data_ok, input, 1: bus completed the transaction.
- data_rdata, input, 32: bus read data, valid with data_ok.

Behaviour:
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- Reset values: rdata_hold = 0, data_sram_rdata = 0, data_req = 0, d_stall = 0.
- data_req = data_sram_en & (state == IDLE). The request is combinational, so there is no added cycle before the bus sees it.
- data_wr = |data_sram_wen.
- data_wdata = data_sram_wdata, passed through.
- data_addr = mapped data_sram_addr.
- data_size derivation:
  - wen 1111 → 2.
  - wen 0011 or 1100 → 1.
  - wen one-hot → 0.
  - Reads → 2.
  - Any other wen pattern → 2 (illegal; core never issues it).
- IDLE → WAIT on data_sram_en & data_addr_ok.
- WAIT:
  - data_data_ok captures data_rdata into rdata_hold.
  - Next state is DONE if data_sram_en = 1, else IDLE (core flushed; result dropped).
  - data_data_ok is ignored in IDLE and DONE. Bus guarantees data_ok arrives at least one cycle after addr_ok.
- DONE → IDLE when ~longest_stall | ~data_sram_en.
- d_stall = data_sram_en & (state != DONE). The core sees d_stall low exactly in DONE, so the memory stage advances on the first cycle the rest of the pipeline is free.
- data_sram_rdata = rdata_hold, registered. It is valid from the cycle after data_ok and stable throughout DONE.
- Writes follow the same path; rdata_hold is still loaded but is don't-care.
- Minimum latency: a read with addr_ok in cycle 0 and data_ok in cycle 1 gives d_stall high in cycles 0–1, low in cycle 2, with rdata valid in cycle 2.
- Back-to-back: after DONE → IDLE, a new request may be issued on the very next cycle. Only one transaction is ever outstanding.
- data_sram_en dropped in IDLE before addr_ok: no transaction, data_req falls.
- Reset asserted mid-WAIT: immediately return to IDLE, data_req = 0. The bus interconnect is reset by the same rst, so no orphan data_ok.
- Address, wen and wdata must be held stable by the core while d_stall = 1. The bridge does not latch them.

Decomposition:
- Shared package (cpu_defines) holds:
  - state encoding localparams S_IDLE, S_WAIT, S_DONE.
  - size codes SIZE_B, SIZE_H, SIZE_W.
  - KSEG constants 3'b100 and 3'b101.
- Natural sub-module: addr_map (combinational KSEG translation, shared with the instruction-side bridge).
- FSM and hold register stay in this module.

Test Plan:
- Read 0x8000_0010, wen 0, addr_ok in cycle 0, data_ok with rdata 0x1234_5678 in cycle 2 → data_addr 0x0000_0010, size 2, d_stall high cycles 0–2, low cycle 3, data_sram_rdata 0x1234_5678.
- Byte write wen 0100, addr 0xA000_0002, wdata 0x00AB_0000 → data_wr 1, size 0, data_addr 0x0000_0002, exactly one req cycle accepted.
- Read completes but longest_stall held high 3 extra cycles → state DONE for 3 cycles, d_stall 0, rdata stable, data_req 0 throughout; IDLE after longest_stall falls.
- addr_ok withheld 4 cycles → data_req high 4 cycles with constant addr, d_stall high; then normal completion.
- rst low during WAIT → data_req 0, d_stall 0, data_sram_rdata 0 immediately; after release, a new read completes normally.
- data_sram_en dropped during WAIT, then data_ok → state IDLE (not DONE), next request issued the following cycle.
